mop_issue_queue: RTL and testbench

- Consumer side of the micro-op cracker: accepts one cracked-instruction bundle per cycle (count plus up to MAX_MOP_CNT micro-ops) and issues micro-ops to the backend one per cycle.
- Sits between decode/crack and rename/dispatch. It is a circular FIFO with multi-entry enqueue, single-entry dequeue, instruction-boundary tagging, flush, and sticky crack-error reporting.

---
 rtl/mop_issue_queue_pkg.sv | 10 +
 rtl/mop_queue_ram.sv | 22 ++
 rtl/mop_issue_queue.sv | 69 ++++++
 tb/tb_mop_issue_queue.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mop_issue_queue_pkg.sv
// mop_issue_queue_pkg: shared micro-op types and bundle sizing
package mop_issue_queue_pkg;
  localparam int MAX_MOP_CNT = 4;
  typedef logic [15:0] micro_op_t;
  localparam int MOP_W = $bits(micro_op_t);
  typedef struct packed {
    micro_op_t mop;
    logic      eoi;
  } entry_t;
endpackage

// File: rtl/mop_queue_ram.sv
// mop_queue_ram: entry storage with per-slot writes at consecutive modulo addresses and one async read
module mop_queue_ram
  import mop_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic [MAX_MOP_CNT-1:0]       wen,
  input  logic [$clog2(DEPTH)-1:0]     waddr,
  input  entry_t [MAX_MOP_CNT-1:0]     wdata,
  input  logic [$clog2(DEPTH)-1:0]     raddr,
  output entry_t                       rdata
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  // slot i lands at waddr+i, wrapping naturally through the AW-bit sum
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_MOP_CNT; i++)
      if (wen[i]) mem[waddr + AW'(i)] <= wdata[i];
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/mop_issue_queue.sv
// mop_issue_queue: circular micro-op FIFO, bundle enqueue, single issue, flush and sticky crack error
module mop_issue_queue
  import mop_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [31:0]             in_cnt,
  input  logic [MAX_MOP_CNT*MOP_W-1:0]   in_mops,
  output logic                           out_valid,
  input  logic                           out_ready,
  output micro_op_t                      out_mop,
  output logic                           out_eoi,
  output logic                           crack_err,
  output logic [$clog2(DEPTH):0]         occupancy
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head, tail;
  logic acc, cnt_ok, cnt_bad, wr, deq;
  logic [MAX_MOP_CNT-1:0] wen;
  entry_t [MAX_MOP_CNT-1:0] wdata;
  entry_t rd;
  assign cnt_ok    = in_cnt >= 1 && in_cnt <= MAX_MOP_CNT;
  assign cnt_bad   = in_cnt < 0 || in_cnt > MAX_MOP_CNT;
  assign in_ready  = occupancy <= (AW+1)'(DEPTH - MAX_MOP_CNT);
  assign out_valid = occupancy != '0;
  assign acc       = in_valid && in_ready && !flush;
  assign wr        = acc && cnt_ok;
  assign deq       = out_valid && out_ready && !flush;
  assign out_mop   = rd.mop;
  assign out_eoi   = out_valid && rd.eoi;
  // unpack the bundle into entries, tagging the last valid slot as end of instruction
  always_comb begin
    for (int i = 0; i < MAX_MOP_CNT; i++) begin
      wdata[i] = '{mop: in_mops[i*MOP_W +: MOP_W], eoi: (i == in_cnt - 1)};
      wen[i]   = wr && (i < in_cnt);
    end
  end
  mop_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .wen  (wen),
    .waddr(tail),
    .wdata(wdata),
    .raddr(head),
    .rdata(rd)
  );
  // pointers, occupancy and sticky error; flush wins over enqueue/dequeue but keeps the error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      crack_err <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (wr) tail <= tail + in_cnt[AW-1:0];
      if (deq) head <= head + 1'b1;
      occupancy <= occupancy + (wr ? in_cnt[AW:0] : '0) - (AW+1)'(deq);
      if (acc && cnt_bad) crack_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mop_issue_queue.sv
// tb_mop_issue_queue: directed scenarios plus random traffic checked against a queue model
module tb_mop_issue_queue;
  import mop_issue_queue_pkg::*;
  localparam int N = MAX_MOP_CNT, D = 8, W = MOP_W;
  logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic signed [31:0] in_cnt = 0;
  logic [N*W-1:0] in_mops = '0;
  logic in_ready, out_valid, out_eoi, crack_err;
  micro_op_t out_mop;
  logic [$clog2(D):0] occupancy;
  int checks = 0, errors = 0;

  mop_issue_queue #(.DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_cnt(in_cnt), .in_mops(in_mops), .out_valid(out_valid), .out_ready(out_ready),
    .out_mop(out_mop), .out_eoi(out_eoi), .crack_err(crack_err), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a plain queue of {mop, eoi} plus a sticky error flag
  logic [W:0] q[$];
  bit merr = 0;
  bit mrdy;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      merr = 0;
    end else if (flush) q.delete();
    else begin
      mrdy = q.size() <= D - N;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && mrdy) begin
        if (in_cnt >= 1 && in_cnt <= N)
          for (int i = 0; i < in_cnt; i++) q.push_back({in_mops[i*W +: W], 1'(i == in_cnt - 1)});
        else if (in_cnt != 0) merr = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() <= D - N));
    chk("crack_err", 32'(crack_err), 32'(merr));
    if (q.size() != 0) begin
      chk("out_mop", 32'(out_mop), 32'(q[0][W:1]));
      chk("out_eoi", 32'(out_eoi), 32'(q[0][0]));
    end else chk("out_eoi_idle", 32'(out_eoi), 32'(0));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bundle(input int cnt, input logic [N*W-1:0] m);
    in_valid = 1;
    in_cnt = cnt;
    in_mops = m;
    tick(1);
    in_valid = 0;
  endtask

  initial begin
    tick(2);
    reset_n = 1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_err", 32'(crack_err), 0);
    // three-mop instruction issues in order with eoi on the last
    out_ready = 1;
    bundle(3, {16'h0, 16'hC003, 16'hB002, 16'hA001});
    chk("t1_a", 32'(out_mop), 32'hA001); chk("t1_a_eoi", 32'(out_eoi), 0);
    tick(1);
    chk("t1_b", 32'(out_mop), 32'hB002); chk("t1_b_eoi", 32'(out_eoi), 0);
    tick(1);
    chk("t1_c", 32'(out_mop), 32'hC003); chk("t1_c_eoi", 32'(out_eoi), 1);
    tick(1);
    chk("t1_occ", 32'(occupancy), 0); chk("t1_err", 32'(crack_err), 0);
    // fill under backpressure: only two bundles fit
    out_ready = 0;
    in_valid = 1;
    in_cnt = 4;
    for (int b = 0; b < 4; b++) begin
      in_mops = {16'(16'h1003 + b*16), 16'(16'h1002 + b*16), 16'(16'h1001 + b*16), 16'(16'h1000 + b*16)};
      tick(1);
      chk("t2_occ", 32'(occupancy), b == 0 ? 4 : 8);
      chk("t2_head", 32'(out_mop), 32'h1000);
    end
    in_valid = 0;
    chk("t2_ready", 32'(in_ready), 0);
    out_ready = 1;
    tick(8);
    chk("t2_drained", 32'(occupancy), 0);
    // advance head from 3 to 6, then straddle the wrap point
    bundle(3, '0);
    tick(3);
    out_ready = 0;
    bundle(4, {16'hD003, 16'hD002, 16'hD001, 16'hD000});
    chk("t3_occ", 32'(occupancy), 4);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_mop", 32'(out_mop), 32'(16'hD000 + k));
      chk("t3_eoi", 32'(out_eoi), 32'(k == 3));
      tick(1);
    end
    chk("t3_occ_end", 32'(occupancy), 0);
    // nop, crack error, oversize count
    out_ready = 0;
    bundle(0, '1);
    chk("t4_nop_err", 32'(crack_err), 0); chk("t4_nop_occ", 32'(occupancy), 0);
    bundle(-1, '1);
    chk("t4_neg_err", 32'(crack_err), 1); chk("t4_neg_rdy", 32'(in_ready), 1);
    bundle(5, '1);
    chk("t4_big_err", 32'(crack_err), 1); chk("t4_big_occ", 32'(occupancy), 0);
    // flush with simultaneous enqueue and dequeue
    bundle(4, {16'h2003, 16'h2002, 16'h2001, 16'h2000});
    bundle(1, {48'h0, 16'h2004});
    chk("t5_occ", 32'(occupancy), 5);
    flush = 1; in_valid = 1; in_cnt = 2; out_ready = 1;
    tick(1);
    flush = 0; in_valid = 0;
    chk("t5_flush_occ", 32'(occupancy), 0);
    chk("t5_flush_valid", 32'(out_valid), 0);
    chk("t5_flush_err", 32'(crack_err), 1);
    // asynchronous reset mid-drain
    out_ready = 0;
    bundle(3, {16'h0, 16'h3002, 16'h3001, 16'h3000});
    chk("t6_occ", 32'(occupancy), 3);
    out_ready = 1;
    #2 reset_n = 0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 0);
    chk("t6_async_occ", 32'(occupancy), 0);
    chk("t6_async_err", 32'(crack_err), 0);
    tick(1);
    reset_n = 1;
    bundle(1, {48'h0, 16'h4444});
    chk("t6_mop", 32'(out_mop), 32'h4444); chk("t6_eoi", 32'(out_eoi), 1);
    tick(1);
    chk("t6_occ_end", 32'(occupancy), 0);
    // random traffic, first half leaning toward full, second half toward empty
    for (int k = 0; k < 3000; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_cnt = $signed($urandom_range(0, 7)) - 1;
      in_mops = {$urandom, $urandom};
      out_ready = $urandom_range(0, 3) < (k < 1500 ? 1 : 3);
      flush = $urandom_range(0, 60) == 0;
      tick(1);
    end
    in_valid = 0; flush = 0; out_ready = 1;
    tick(10);
    chk("final_occ", 32'(occupancy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
